// File: rtl/mod_sub_pkg.sv
// Shared definitions for the bit-serial modular subtractor.
package mod_sub_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mod_sub_serial_if.sv
// Request/response bundle between a requester and mod_sub_serial.
interface mod_sub_serial_if
    import mod_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic             ready;
    logic             done;
    logic             busy;
    logic [WIDTH-1:0] result;

    modport master (
        output start, a, b, n,
        input  ready, done, busy, result
    );

    modport slave (
        input  start, a, b, n,
        output ready, done, busy, result
    );

endinterface

// File: rtl/serial_bit_cell.sv
// One-bit full adder/subtractor: sub=1 yields borrow-out, sub=0 yields carry-out.
module serial_bit_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    input  logic sub,
    output logic s,
    output logic cout
);

    always_comb begin
        s = x ^ y ^ cin;
        if (sub) begin
            cout = (~x & y) | (~(x ^ y) & cin);
        end else begin
            cout = (x & y) | ((x ^ y) & cin);
        end
    end

endmodule

// File: rtl/mod_sub_serial.sv
// Constant-time bit-serial (a - b) mod n: WIDTH borrow cycles, then WIDTH cycles adding n back.
module mod_sub_serial
    import mod_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    mod_sub_serial_if.slave  bus
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] n_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] result;
    logic             br;
    logic             fix_en;
    logic             done;
    logic             ready;
    logic             busy;

    logic             last_c;
    logic             cell_x;
    logic             cell_y;
    logic             cell_sub;
    logic             cell_s;
    logic             cell_cout;

    assign last_c = (cnt == CNT_W'(WIDTH - 1));

    // Next-state logic and cell operand selection.
    always_comb begin
        state_next = state;
        cell_x     = 1'b0;
        cell_y     = 1'b0;
        cell_sub   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = SUB;
                end
            end
            SUB: begin
                cell_x   = a_sh[0];
                cell_y   = b_sh[0];
                cell_sub = 1'b1;
                if (last_c) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                // n is always added, gated to zero when no wrap is needed, to keep timing flat
                cell_x = acc[0];
                cell_y = n_sh[0] & fix_en;
                if (last_c) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
        endcase
    end

    serial_bit_cell u_cell (
        .x    (cell_x),
        .y    (cell_y),
        .cin  (br),
        .sub  (cell_sub),
        .s    (cell_s),
        .cout (cell_cout)
    );

    // State, counter, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            br     <= 1'b0;
            fix_en <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            n_sh   <= '0;
            acc    <= '0;
            result <= '0;
            done   <= 1'b0;
            ready  <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == DONE);
            ready <= (state_next == IDLE);
            busy  <= (state_next == SUB) || (state_next == FIX);

            if (state_next != state) begin
                cnt <= '0;
            end else if ((state == SUB) || (state == FIX)) begin
                cnt <= cnt + CNT_W'(1);
            end

            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh <= bus.a;
                        b_sh <= bus.b;
                        n_sh <= bus.n;
                        br   <= 1'b0;
                    end
                end
                SUB: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    acc  <= {cell_s, acc[WIDTH-1:1]};
                    br   <= last_c ? 1'b0 : cell_cout;
                    if (last_c) begin
                        fix_en <= cell_cout;
                    end
                end
                FIX: begin
                    // acc shifts out the difference LSB-first while the sum shifts in at the top
                    n_sh <= n_sh >> 1;
                    acc  <= {cell_s, acc[WIDTH-1:1]};
                    br   <= last_c ? 1'b0 : cell_cout;
                    if (last_c) begin
                        result <= {cell_s, acc[WIDTH-1:1]};
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

    assign bus.result = result;
    assign bus.done   = done;
    assign bus.ready  = ready;
    assign bus.busy   = busy;

endmodule

// File: tb/tb_mod_sub_serial.sv
// Bench for mod_sub_serial: directed WIDTH=8 scenarios plus a randomized WIDTH=32 sweep.
module tb_mod_sub_serial;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mod_sub_serial_if #(.WIDTH(8))  i8  ();
    mod_sub_serial_if #(.WIDTH(32)) i32 ();

    mod_sub_serial #(.WIDTH(8), .CNT_W(4)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (i8)
    );

    mod_sub_serial #(.WIDTH(32), .CNT_W(6)) u32 (
        .clk (clk),
        .rst (rst),
        .bus (i32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: subtract, add n back when a borrow occurred, wrap to w bits.
    function automatic logic [63:0] ref_sub(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] n, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return (a - b + ((a < b) ? n : 64'd0)) & mask;
    endfunction

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
        @(negedge clk);
        i8.a = a; i8.b = b; i8.n = n; i8.start = 1'b1;
        @(posedge clk); #1;
        i8.start = 1'b0;
    endtask

    task automatic wait8(input int lat0, output int lat);
        lat = lat0;
        while (!i8.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
        int lat;
        go8(a, b, n);
        check($sformatf("busy8 %0d-%0d", a, b), 64'(i8.busy), 64'd1);
        wait8(1, lat);
        check($sformatf("lat8 %0d-%0d", a, b), 64'(lat), 64'd17);
        check($sformatf("res8 %0d-%0d mod %0d", a, b, n), 64'(i8.result), ref_sub(64'(a), 64'(b), 64'(n), 8));
        @(posedge clk); #1;
        check($sformatf("ready8 %0d-%0d", a, b), 64'(i8.ready), 64'd1);
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n);
        int lat;
        @(negedge clk);
        i32.a = a; i32.b = b; i32.n = n; i32.start = 1'b1;
        @(posedge clk); #1;
        i32.start = 1'b0;
        lat = 1;
        while (!i32.done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("lat32", 64'(lat), 64'd65);
        check($sformatf("res32 %0d-%0d mod %0d", a, b, n), 64'(i32.result), ref_sub(64'(a), 64'(b), 64'(n), 32));
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int seen;
        int first;
        int second;
        logic [31:0] ra, rb, rn;

        rst = 1'b1;
        i8.start = 1'b0;  i8.a = '0;  i8.b = '0;  i8.n = '0;
        i32.start = 1'b0; i32.a = '0; i32.b = '0; i32.n = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst ready", 64'(i8.ready), 64'd1);
        check("rst busy", 64'(i8.busy), 64'd0);
        check("rst done", 64'(i8.done), 64'd0);
        check("rst result", 64'(i8.result), 64'd0);
        check("rst ready32", 64'(i32.ready), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed residues, including the boundary cases and out-of-range operands
        op8(8'd200, 8'd50,  8'd251);
        op8(8'd50,  8'd200, 8'd251);
        op8(8'd77,  8'd77,  8'd251);
        op8(8'd0,   8'd250, 8'd251);
        op8(8'd123, 8'd0,   8'd251);
        op8(8'd250, 8'd10,  8'd100);
        op8(8'd10,  8'd250, 8'd100);

        // A start while busy must be ignored
        go8(8'd200, 8'd50, 8'd251);
        repeat (4) @(posedge clk);
        #1;
        check("ready mid-op", 64'(i8.ready), 64'd0);
        i8.a = 8'd1; i8.b = 8'd1; i8.start = 1'b1;
        @(posedge clk); #1;
        i8.start = 1'b0;
        wait8(6, lat);
        check("ignore lat", 64'(lat), 64'd17);
        check("ignore result", 64'(i8.result), 64'd150);
        @(posedge clk); #1;

        // Reset in cycle 9 aborts the operation with no done pulse
        go8(8'd77, 8'd10, 8'd251);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort ready", 64'(i8.ready), 64'd1);
        check("abort busy", 64'(i8.busy), 64'd0);
        check("abort done", 64'(i8.done), 64'd0);
        check("abort result", 64'(i8.result), 64'd0);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (i8.done) seen++;
        end
        check("abort no done", 64'(seen), 64'd0);
        op8(8'd200, 8'd50, 8'd251);

        // start held high for cycles 0..39
        @(negedge clk);
        i8.a = 8'd10; i8.b = 8'd20; i8.n = 8'd251; i8.start = 1'b1;
        @(posedge clk); #1;
        seen = 0; first = -1; second = -1;
        for (int c = 1; c < 40; c++) begin
            if (i8.done) begin
                seen++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
                check($sformatf("held res c%0d", c), 64'(i8.result), 64'd241);
            end
            @(posedge clk); #1;
        end
        i8.start = 1'b0;
        check("held count", 64'(seen), 64'd2);
        check("held first", 64'(first), 64'd17);
        check("held second", 64'(second), 64'd35);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Random sweep at WIDTH=32 with odd moduli
        for (int i = 0; i < 600; i++) begin
            rn = $urandom | 32'd1;
            ra = $urandom % rn;
            rb = $urandom % rn;
            if (i % 10 == 3) rb = ra;
            if (i % 10 == 7) rb = 32'd0;
            if (i % 10 == 9) begin
                ra = 32'd0;
                rb = rn - 32'd1;
            end
            op32(ra, rb, rn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
